// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait,
    StResp
  } dmem_state_e;

  // RISC-V load func3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // RISC-V store func3 encodings
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester (p0 = core LSU, p1 = loader/debug) and data-memory signals of dmem_arbiter.
interface dmem_arbiter_if;

  logic        p0_req_valid;
  logic        p0_req_ready;
  logic        p0_req_we;
  logic [63:0] p0_req_addr;
  logic [63:0] p0_req_wdata;
  logic [2:0]  p0_req_func3;
  logic        p0_rsp_valid;
  logic        p0_rsp_ready;
  logic [63:0] p0_rsp_rdata;
  logic        p0_rsp_err;

  logic        p1_req_valid;
  logic        p1_req_ready;
  logic        p1_req_we;
  logic [63:0] p1_req_addr;
  logic [63:0] p1_req_wdata;
  logic [2:0]  p1_req_func3;
  logic        p1_rsp_valid;
  logic        p1_rsp_ready;
  logic [63:0] p1_rsp_rdata;
  logic        p1_rsp_err;

  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic [2:0]  mem_func3;
  logic [63:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata, p0_req_func3, p0_rsp_ready,
    output p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_func3, p1_rsp_ready,
    output p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    output mem_we, mem_re, mem_addr, mem_data, mem_func3,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata, p0_req_func3, p0_rsp_ready,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_func3, p1_rsp_ready,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    input  mem_we, mem_re, mem_addr, mem_data, mem_func3,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_align_chk.sv
// Combinational access check: decodes access size from func3 and flags misaligned
// addresses and illegal func3 encodings.
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic       we_i,
  input  logic [2:0] func3_i,
  input  logic [2:0] addr_i,
  output logic       misaligned_o,
  output logic       illegal_o
);

  logic [1:0] size;

  always_comb begin
    size      = 2'd3;
    illegal_o = 1'b0;
    if (we_i) begin
      unique case (func3_i)
        SB:      size = 2'd0;
        SH:      size = 2'd1;
        SW:      size = 2'd2;
        SD:      size = 2'd3;
        default: illegal_o = 1'b1;
      endcase
    end else begin
      unique case (func3_i)
        LB, LBU: size = 2'd0;
        LH, LHU: size = 2'd1;
        LW, LWU: size = 2'd2;
        LD:      size = 2'd3;
        default: illegal_o = 1'b1;
      endcase
    end

    unique case (size)
      2'd0:    misaligned_o = 1'b0;
      2'd1:    misaligned_o = addr_i[0];
      2'd2:    misaligned_o = |addr_i[1:0];
      default: misaligned_o = |addr_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter, one transaction in flight. Fixed priority (port 0) by
// default; define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] LastCnt = 2'(RD_LAT - 1);

  dmem_state_e state_q, state_d;

  logic [NUM_PORTS-1:0] req_valid;
  logic                 sel;
  logic                 accept;
  logic                 misaligned;
  logic                 illegal;
  logic                 sel_we;
  logic [63:0]          sel_addr;
  logic [63:0]          sel_wdata;
  logic [2:0]           sel_func3;
  logic                 rsp_ready;

  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  cnt_q, cnt_d;

  assign req_valid = {bus.p1_req_valid, bus.p0_req_valid};
  // Gated by rst_n so ready stays low while reset holds the FSM in idle.
  assign accept    = rst_n && (state_q == StIdle) && (|req_valid);

`ifdef DMEM_ARB_RR_EN
  logic prio_q;

  assign sel = (&req_valid) ? prio_q : req_valid[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= ~sel;
    end
  end
`else
  assign sel = ~req_valid[0];
`endif

  assign sel_we    = sel ? bus.p1_req_we    : bus.p0_req_we;
  assign sel_addr  = sel ? bus.p1_req_addr  : bus.p0_req_addr;
  assign sel_wdata = sel ? bus.p1_req_wdata : bus.p0_req_wdata;
  assign sel_func3 = sel ? bus.p1_req_func3 : bus.p0_req_func3;
  assign rsp_ready = gnt_q ? bus.p1_rsp_ready : bus.p0_rsp_ready;

  dmem_align_chk u_align_chk (
    .we_i         (sel_we),
    .func3_i      (sel_func3),
    .addr_i       (sel_addr[2:0]),
    .misaligned_o (misaligned),
    .illegal_o    (illegal)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    func3_d = func3_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          gnt_d   = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          func3_d = sel_func3;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = misaligned | illegal;
          // Faulting requests never touch memory.
          state_d = (misaligned | illegal) ? StResp : StIssue;
        end
      end
      StIssue: begin
        state_d = we_q ? StResp : StRdWait;
      end
      StRdWait: begin
        if (cnt_q == LastCnt) begin
          rdata_d = bus.mem_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      func3_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      func3_q <= func3_d;
      cnt_q   <= cnt_d;
    end
  end

  logic in_issue;
  logic rsp0;
  logic rsp1;

  assign in_issue = (state_q == StIssue);
  assign rsp0     = (state_q == StResp) && !gnt_q;
  assign rsp1     = (state_q == StResp) && gnt_q;

  always_comb begin
    bus.p0_req_ready = accept & ~sel;
    bus.p1_req_ready = accept & sel;
    bus.p0_rsp_valid = rsp0;
    bus.p1_rsp_valid = rsp1;
    bus.p0_rsp_rdata = rsp0 ? rdata_q : '0;
    bus.p1_rsp_rdata = rsp1 ? rdata_q : '0;
    bus.p0_rsp_err   = rsp0 & err_q;
    bus.p1_rsp_err   = rsp1 & err_q;
    bus.mem_we       = in_issue & we_q;
    bus.mem_re       = in_issue & ~we_q;
    bus.mem_addr     = in_issue ? addr_q  : '0;
    bus.mem_data     = in_issue ? wdata_q : '0;
    bus.mem_func3    = in_issue ? func3_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table of single transactions plus
// tie, backpressure and reset-in-flight sequences against a small memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned RD_LAT = 1;
  localparam logic [63:0] DataA = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] DataB = 64'h0123456789ABCDEF;
  localparam logic [63:0] DataC = 64'h5555AAAA3333CCCC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: whole 64-bit words, read data valid RD_LAT cycles after mem_re.
  logic [63:0] mem     [0:31];
  logic [63:0] rd_pipe [0:2];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:3]] <= bus.mem_data;
    rd_pipe[0] <= bus.mem_re ? mem[bus.mem_addr[7:3]] : 64'hBAD0BAD0BAD0BAD0;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  int we_cnt = 0;
  int re_cnt = 0;
  int p0_rsp_seen = 0;
  always @(negedge clk) begin
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.mem_re) re_cnt <= re_cnt + 1;
    if (bus.p0_rsp_valid) p0_rsp_seen <= p0_rsp_seen + 1;
  end

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  func3;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          exp_re;
  } vec_t;

  vec_t vecs [12];

  task automatic drive_req(input logic p, input logic v, input logic we, input logic [63:0] a,
                           input logic [63:0] wd, input logic [2:0] f3);
    if (p) begin
      bus.p1_req_valid = v; bus.p1_req_we = we; bus.p1_req_addr = a;
      bus.p1_req_wdata = wd; bus.p1_req_func3 = f3;
    end else begin
      bus.p0_req_valid = v; bus.p0_req_we = we; bus.p0_req_addr = a;
      bus.p0_req_wdata = wd; bus.p0_req_func3 = f3;
    end
  endtask

  function automatic logic rd_ready(input logic p);
    return p ? bus.p1_req_ready : bus.p0_req_ready;
  endfunction

  function automatic logic rd_rsp_valid(input logic p);
    return p ? bus.p1_rsp_valid : bus.p0_rsp_valid;
  endfunction

  function automatic logic any_out();
    return |{bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p1_rsp_valid,
             bus.p0_rsp_rdata, bus.p1_rsp_rdata, bus.p0_rsp_err, bus.p1_rsp_err,
             bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_data, bus.mem_func3};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int we0, re0, lat;
    bit ok;
    @(negedge clk);
    drive_req(v.port, 1'b1, v.we, v.addr, v.wdata, v.func3);
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_ready(v.port)) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    check($sformatf("v%0d_accept", idx), 64'(ok), 64'd1);
    we0 = we_cnt;
    re0 = re_cnt;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) drive_req(v.port, 1'b0, v.we, v.addr, v.wdata, v.func3);
      #1;
      lat++;
      if (rd_rsp_valid(v.port)) break;
    end
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_rdata", idx), v.port ? bus.p1_rsp_rdata : bus.p0_rsp_rdata,
          v.exp_rdata);
    check($sformatf("v%0d_err", idx), 64'(v.port ? bus.p1_rsp_err : bus.p0_rsp_err),
          64'(v.exp_err));
    @(negedge clk); #1;
    check($sformatf("v%0d_we_pulses", idx), 64'(we_cnt - we0), 64'(v.exp_we));
    check($sformatf("v%0d_re_pulses", idx), 64'(re_cnt - re0), 64'(v.exp_re));
    check($sformatf("v%0d_rsp_done", idx), 64'(rd_rsp_valid(v.port)), 64'd0);
  endtask

  task automatic tie_test();
    int rem0, rem1, n0, n1;
    int glog[$];
    int exp_order[3];
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0};
`else
    exp_order = '{0, 0, 1};
`endif
    rem0 = 2; rem1 = 1; n0 = 0; n1 = 0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 64'h10, 64'h0, LD);
    drive_req(1'b1, 1'b1, 1'b0, 64'h18, 64'h0, LD);
    for (int c = 0; c < 60; c++) begin
      bus.p0_req_valid = (rem0 > 0);
      bus.p1_req_valid = (rem1 > 0);
      #1;
      if (bus.p0_rsp_valid) begin n0++; check("tie_p0_rdata", bus.p0_rsp_rdata, DataA); end
      if (bus.p1_rsp_valid) begin n1++; check("tie_p1_rdata", bus.p1_rsp_rdata, DataB); end
      if (bus.p0_req_ready) begin glog.push_back(0); rem0--; end
      if (bus.p1_req_ready) begin glog.push_back(1); rem1--; end
      if (n0 == 2 && n1 == 1) break;
      @(negedge clk);
    end
    bus.p0_req_valid = 1'b0;
    bus.p1_req_valid = 1'b0;
    check("tie_grant_count", 64'(glog.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tie_grant%0d", i), 64'((i < glog.size()) ? glog[i] : 9),
            64'(exp_order[i]));
    end
    check("tie_p0_rsps", 64'(n0), 64'd2);
    check("tie_p1_rsps", 64'(n1), 64'd1);
    @(negedge clk);
  endtask

  task automatic backpressure_test();
    bit ok;
    bus.p0_rsp_ready = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 64'h10, 64'h0, LD);
    #1;
    check("bp_p0_accept", 64'(bus.p0_req_ready), 64'd1);
    @(negedge clk);
    bus.p0_req_valid = 1'b0;
    drive_req(1'b1, 1'b1, 1'b0, 64'h18, 64'h0, LD);
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.p0_rsp_valid) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    check("bp_rsp_seen", 64'(ok), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), 64'(bus.p0_rsp_valid), 64'd1);
      check($sformatf("bp_rdata%0d", k), bus.p0_rsp_rdata, DataA);
      check($sformatf("bp_p1_stall%0d", k), 64'(bus.p1_req_ready), 64'd0);
      @(negedge clk); #1;
    end
    bus.p0_rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_rsp_released", 64'(bus.p0_rsp_valid), 64'd0);
    check("bp_p1_granted", 64'(bus.p1_req_ready), 64'd1);
    @(negedge clk);
    bus.p1_req_valid = 1'b0;
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.p1_rsp_valid) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    check("bp_p1_rsp_seen", 64'(ok), 64'd1);
    check("bp_p1_rdata", bus.p1_rsp_rdata, DataB);
    @(negedge clk);
  endtask

  task automatic reset_rdwait_test();
    int base;
    bit ok;
    base = p0_rsp_seen;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 64'h10, 64'h0, LD);
    #1;
    check("rst_p0_accept", 64'(bus.p0_req_ready), 64'd1);
    @(negedge clk);
    bus.p0_req_valid = 1'b0;
    #1;
    check("rst_issue_re", 64'(bus.mem_re), 64'd1);
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b0, 64'h18, 64'h0, LD);
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", 64'(any_out()), 64'd0);
    @(negedge clk); #1;
    check("rst_outputs_hold_zero", 64'(any_out()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.p1_req_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    check("rst_p1_accept", 64'(ok), 64'd1);
    @(negedge clk);
    bus.p1_req_valid = 1'b0;
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.p1_rsp_valid) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    check("rst_p1_rsp_seen", 64'(ok), 64'd1);
    check("rst_p1_rdata", bus.p1_rsp_rdata, DataB);
    check("rst_p1_err", 64'(bus.p1_rsp_err), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    check("rst_no_p0_rsp", 64'(p0_rsp_seen - base), 64'd0);
  endtask

  initial begin
    // port, we, addr, wdata, func3, exp_rdata, exp_err, exp_lat, exp_we, exp_re
    vecs[0]  = '{1'b0, 1'b1, 64'h10, DataA, SD,     64'h0, 1'b0, 2,          1, 0};
    vecs[1]  = '{1'b0, 1'b0, 64'h10, 64'h0, LD,     DataA, 1'b0, 2 + RD_LAT, 0, 1};
    vecs[2]  = '{1'b1, 1'b1, 64'h18, DataB, SD,     64'h0, 1'b0, 2,          1, 0};
    vecs[3]  = '{1'b1, 1'b0, 64'h18, 64'h0, LD,     DataB, 1'b0, 2 + RD_LAT, 0, 1};
    vecs[4]  = '{1'b1, 1'b0, 64'h06, 64'h0, LW,     64'h0, 1'b1, 1,          0, 0};
    vecs[5]  = '{1'b0, 1'b0, 64'h10, 64'h0, 3'b111, 64'h0, 1'b1, 1,          0, 0};
    vecs[6]  = '{1'b0, 1'b1, 64'h03, DataB, SH,     64'h0, 1'b1, 1,          0, 0};
    vecs[7]  = '{1'b1, 1'b1, 64'h20, DataB, 3'b100, 64'h0, 1'b1, 1,          0, 0};
    vecs[8]  = '{1'b0, 1'b0, 64'h14, 64'h0, LD,     64'h0, 1'b1, 1,          0, 0};
    vecs[9]  = '{1'b1, 1'b1, 64'h20, DataC, SD,     64'h0, 1'b0, 2,          1, 0};
    vecs[10] = '{1'b0, 1'b0, 64'h20, 64'h0, LD,     DataC, 1'b0, 2 + RD_LAT, 0, 1};
    vecs[11] = '{1'b0, 1'b1, 64'h27, 64'hAB, SB,    64'h0, 1'b0, 2,          1, 0};

    drive_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 3'b000);
    bus.p0_rsp_ready = 1'b1;
    bus.p1_rsp_ready = 1'b1;
    // Pending request during reset must not be acknowledged.
    drive_req(1'b0, 1'b1, 1'b1, 64'h10, 64'hFFFF, SD);
    #23;
    check("reset_outputs_zero", 64'(any_out()), 64'd0);
    drive_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
    tie_test();
    backpressure_test();
    reset_rdwait_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: memory read latency in cycles, legal range 1-3.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports pN_req_valid, input, 1 bit, N=0,1: request valid (port 0 = core LSU, port 1 = loader/debug).
REQ-005 SHALL have ports pN_req_ready, output, 1 bit: request accepted this cycle.
REQ-006 SHALL have ports pN_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have ports pN_req_addr, input, 64 bits: byte address.
REQ-008 SHALL have ports pN_req_wdata, input, 64 bits: store data, right-aligned.
REQ-009 SHALL have ports pN_req_func3, input, 3 bits: RISC-V load/store func3.
REQ-010 SHALL have ports pN_rsp_valid, output, 1 bit: response valid.
REQ-011 SHALL have ports pN_rsp_ready, input, 1 bit: requester accepts the response.
REQ-012 SHALL have ports pN_rsp_rdata, output, 64 bits: load result, already extended.
REQ-013 SHALL have ports pN_rsp_err, output, 1 bit: misaligned or illegal access.
REQ-014 SHALL have ports mem_we, mem_re, output, 1 bit each: data-memory write and read strobes.
REQ-015 SHALL have port mem_addr, output, 64 bits, and port mem_data, output, 64 bits.
REQ-016 SHALL have port mem_func3, output, 3 bits, and port mem_rdata, input, 64 bits: read data, valid RD_LAT cycles after mem_re.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RD_WAIT and RESP, with at most one transaction in flight.
REQ-018 SHALL, in IDLE, grant one valid requester, assert its pN_req_ready for exactly one cycle, latch the request and go to ISSUE.
REQ-019 SHALL use fixed priority on simultaneous requests: port 0 wins (see REQ-030 for the alternative).
REQ-020 SHALL, in ISSUE, drive mem_addr, mem_data and mem_func3 from the latched request and pulse mem_we or mem_re for exactly one cycle.
REQ-021 SHALL, after a store is issued, go to RESP with rdata=0 and err=0.
REQ-022 SHALL, after a load is issued, go to RD_WAIT, count RD_LAT cycles, capture mem_rdata on the last of them and go to RESP.
REQ-023 SHALL, in RESP, hold pN_rsp_valid, rdata and err stable on the granted port only until pN_rsp_ready is high, then return to IDLE.
REQ-024 SHALL give a best-case load latency of req-accept-to-rsp_valid = 2+RD_LAT cycles, and 2 cycles for a store.
REQ-025 SHALL flag a request misaligned when the address low bits are nonzero for its size: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
REQ-026 SHALL treat func3=111, and store func3 values above 011, as illegal.
REQ-027 SHALL handle misaligned and illegal requests by skipping ISSUE, leaving mem_we and mem_re low, and going straight to RESP with err=1 and rdata=0.
REQ-028 SHALL keep mem_we and mem_re low and pN_req_ready low in every state except those named in REQ-018 and REQ-020.

Reset
REQ-029 SHALL, while rst_n=0, go to IDLE, drive all outputs to 0, clear latched data and the counter, and abandon any in-flight transaction without a response.

Configuration
REQ-030 SHALL, with macro DMEM_ARB_RR_EN defined, use round-robin arbitration: the port not granted last wins a tie, and after reset port 0 has priority.
REQ-031 SHALL, with DMEM_ARB_RR_EN undefined, use fixed priority (port 0 wins) and contain no round-robin state flop.

Structure
REQ-032 SHALL place the FSM state enum, func3 encodings (LB..LWU, SB..SD) and the constant NUM_PORTS=2 in shared package dmem_pkg.
REQ-033 SHALL put the alignment and legality check in one combinational sub-module, dmem_align_chk, taking func3 and addr[2:0] and returning misaligned and illegal.

Verification
REQ-034 SHALL cover: p0 store SD addr=0x10 data=0xDEADBEEFCAFEF00D, then p0 load LD addr=0x10 -> one mem_we pulse, then rsp rdata=0xDEADBEEFCAFEF00D, err=0, rsp_valid 3 cycles after accept (RD_LAT=1).
REQ-035 SHALL cover: p0 and p1 loads asserted in the same cycle -> p0 served first and p1 next; with DMEM_ARB_RR_EN a second tie goes to p1.
REQ-036 SHALL cover: p1 LW addr=0x6 -> rsp err=1, rdata=0, no mem_re pulse.
REQ-037 SHALL cover: p0 load with rsp_ready held low for 5 cycles -> rsp_valid and rdata stable, p1 stalled, served after the handshake.
REQ-038 SHALL cover: rst_n asserted in RD_WAIT -> all outputs 0 immediately, no response; the next request completes normally.
REQ-039 SHALL cover: func3=111 load on p0 -> err=1, no memory access.
